// File: rtl/ray_dispatcher_pkg.sv
// rtl/ray_dispatcher_pkg.sv - shared ray types, unit/dispatcher states and display defines
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 640
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 480
`endif
`ifndef H_BITS
`define H_BITS 10
`endif
`ifndef V_BITS
`define V_BITS 10
`endif

package ray_dispatcher_pkg;

    // 16.16 signed fixed point
    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    typedef enum logic [1:0] {
        RU_Idle,
        RU_March,
        RU_Shade,
        RU_Done
    } RayUnitState;

    typedef enum logic [1:0] {
        DS_Idle,
        DS_Dispatch,
        DS_Drain
    } DispatchState;

endpackage

// File: rtl/ray_dispatcher_rr_arbiter.sv
// rtl/ray_dispatcher_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr_i
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             any_o
);

    always_comb begin
        logic [PTR_W-1:0] sel;
        grant_o = '0;
        any_o   = 1'b0;
        sel     = '0;
        for (int k = 0; k < N; k++) begin
            sel = PTR_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[sel]) begin
                grant_o[sel] = 1'b1;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// rtl/ray_dispatcher.sv - issues one pixel per grant to ready ray units in raster order
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int NUM_UNITS      = 4,
    parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
    parameter int H_BITS         = `H_BITS,
    parameter int V_BITS         = `V_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 frame_start_in,
    input  vec3                  cam_origin_in,
    input  vec3                  cam_forward_in,
    input  logic [2:0]           fractal_sel_in,
    input  logic [NUM_UNITS-1:0] unit_ready_in,
    output logic [NUM_UNITS-1:0] unit_valid_out,
    output vec3                  ray_origin_out,
    output vec3                  ray_direction_out,
    output logic [2:0]           fractal_sel_out,
    output logic [H_BITS-1:0]    hcount_out,
    output logic [V_BITS-1:0]    vcount_out,
    output logic                 busy_out,
    output logic                 frame_done_out
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    DispatchState state_q, state_d;

    vec3                  origin_q, origin_d;
    vec3                  forward_q, forward_d;
    logic [2:0]           sel_q, sel_d;
    logic [H_BITS-1:0]    cur_h_q, cur_h_d;
    logic [V_BITS-1:0]    cur_v_q, cur_v_d;
    logic [NUM_UNITS-1:0] valid_q, valid_d;
    logic [H_BITS-1:0]    h_q, h_d;
    logic [V_BITS-1:0]    v_q, v_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 done_q, done_d;

    logic [NUM_UNITS-1:0] eligible;
    logic [NUM_UNITS-1:0] grant;
    logic                 any_grant;
    logic [PTR_W-1:0]     next_ptr;
    logic                 last_pixel;
    logic                 last_col;
    logic                 drain_done;

    // A unit issued last cycle may still show ready; valid_q doubles as the issue mask
    assign eligible = unit_ready_in & ~valid_q;

    rr_arbiter #(
        .N     (NUM_UNITS),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (any_grant)
    );

    always_comb begin
        next_ptr = ptr_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) begin
                next_ptr = PTR_W'((i + 1) % NUM_UNITS);
            end
        end
    end

    assign last_col   = (cur_h_q == H_BITS'(DISPLAY_WIDTH - 1));
    assign last_pixel = last_col && (cur_v_q == V_BITS'(DISPLAY_HEIGHT - 1));
    assign drain_done = (&unit_ready_in) && (valid_q == '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= DS_Idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_Idle: begin
                if (frame_start_in) begin
                    state_d = DS_Dispatch;
                end
            end
            DS_Dispatch: begin
                if (any_grant && last_pixel) begin
                    state_d = DS_Drain;
                end
            end
            DS_Drain: begin
                if (drain_done) begin
                    state_d = DS_Idle;
                end
            end
            default: state_d = DS_Idle;
        endcase
    end

    always_comb begin
        origin_d  = origin_q;
        forward_d = forward_q;
        sel_d     = sel_q;
        cur_h_d   = cur_h_q;
        cur_v_d   = cur_v_q;
        valid_d   = '0;
        h_d       = h_q;
        v_d       = v_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        case (state_q)
            DS_Idle: begin
                if (frame_start_in) begin
                    origin_d  = cam_origin_in;
                    forward_d = cam_forward_in;
                    sel_d     = fractal_sel_in;
                    cur_h_d   = '0;
                    cur_v_d   = '0;
                end
            end
            DS_Dispatch: begin
                if (any_grant) begin
                    valid_d = grant;
                    h_d     = cur_h_q;
                    v_d     = cur_v_q;
                    ptr_d   = next_ptr;
                    if (last_col) begin
                        cur_h_d = '0;
                        cur_v_d = cur_v_q + 1'b1;
                    end else begin
                        cur_h_d = cur_h_q + 1'b1;
                    end
                end
            end
            DS_Drain: begin
                done_d = drain_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            origin_q  <= '0;
            forward_q <= '0;
            sel_q     <= '0;
            cur_h_q   <= '0;
            cur_v_q   <= '0;
            valid_q   <= '0;
            h_q       <= '0;
            v_q       <= '0;
            ptr_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            origin_q  <= origin_d;
            forward_q <= forward_d;
            sel_q     <= sel_d;
            cur_h_q   <= cur_h_d;
            cur_v_q   <= cur_v_d;
            valid_q   <= valid_d;
            h_q       <= h_d;
            v_q       <= v_d;
            ptr_q     <= ptr_d;
            done_q    <= done_d;
        end
    end

    assign unit_valid_out    = valid_q;
    assign ray_origin_out    = origin_q;
    assign ray_direction_out = forward_q;
    assign fractal_sel_out   = sel_q;
    assign hcount_out        = h_q;
    assign vcount_out        = v_q;
    assign busy_out          = (state_q != DS_Idle);
    assign frame_done_out    = done_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// tb/tb_ray_dispatcher.sv - directed vector bench for ray_dispatcher on a 4x2 display
module tb_ray_dispatcher;
    import ray_dispatcher_pkg::*;

    localparam int NU = 4;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 3;
    localparam int VB = 2;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          frame_start_in = 1'b0;
    vec3           cam_origin_in;
    vec3           cam_forward_in;
    logic [2:0]    fractal_sel_in;
    logic [NU-1:0] unit_ready_in;
    logic [NU-1:0] unit_valid_out;
    vec3           ray_origin_out;
    vec3           ray_direction_out;
    logic [2:0]    fractal_sel_out;
    logic [HB-1:0] hcount_out;
    logic [VB-1:0] vcount_out;
    logic          busy_out;
    logic          frame_done_out;

    int errors = 0;
    int checks = 0;

    localparam logic [95:0] ORG1 = {32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    localparam logic [95:0] ORG2 = {32'hFFFF_0000, 32'h0000_8000, 32'h0010_0000};
    localparam logic [95:0] ORG3 = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};
    localparam logic [95:0] FWD1 = {32'h0000_0000, 32'h0000_0000, 32'h0001_0000};

    ray_dispatcher #(
        .NUM_UNITS      (NU),
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H),
        .H_BITS         (HB),
        .V_BITS         (VB)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .frame_start_in    (frame_start_in),
        .cam_origin_in     (cam_origin_in),
        .cam_forward_in    (cam_forward_in),
        .fractal_sel_in    (fractal_sel_in),
        .unit_ready_in     (unit_ready_in),
        .unit_valid_out    (unit_valid_out),
        .ray_origin_out    (ray_origin_out),
        .ray_direction_out (ray_direction_out),
        .fractal_sel_out   (fractal_sel_out),
        .hcount_out        (hcount_out),
        .vcount_out        (vcount_out),
        .busy_out          (busy_out),
        .frame_done_out    (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       start;
        logic [3:0] ready;
        logic [3:0] valid;
        int         h;
        int         v;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic s, input logic [3:0] r, input logic [3:0] val,
                                input int h, input int v, input logic b, input logic d);
        vec_t e;
        e.start = s; e.ready = r; e.valid = val; e.h = h; e.v = v; e.busy = b; e.done = d;
        tbl.push_back(e);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Steps until n grants are seen, checking raster order, one-hot and forbidden units
    task automatic issue_grants(input int first_p, input int n, input logic [3:0] forbid, input string tag);
        int p;
        int cyc;
        p = first_p;
        cyc = 0;
        while (p < first_p + n && cyc < 60) begin
            step();
            cyc++;
            if (unit_valid_out != '0) begin
                check({tag, " onehot"}, 128'($onehot(unit_valid_out)), 128'(1));
                check({tag, " forbidden unit"}, 128'(unit_valid_out & forbid), 128'(0));
                check($sformatf("%s h p%0d", tag, p), 128'(hcount_out), 128'(p % W));
                check($sformatf("%s v p%0d", tag, p), 128'(vcount_out), 128'(p / W));
                p++;
            end
        end
        check({tag, " grant count"}, 128'(p - first_p), 128'(n));
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int cyc;
        cyc = 0;
        while (!frame_done_out && cyc < maxc) begin
            step();
            cyc++;
        end
        check({tag, " frame_done seen"}, 128'(frame_done_out), 128'(1));
    endtask

    initial begin
        cam_origin_in  = ORG1;
        cam_forward_in = FWD1;
        fractal_sel_in = 3'd3;
        unit_ready_in  = 4'hF;

        step();
        step();
        check("reset valid", 128'(unit_valid_out), 128'(0));
        check("reset h", 128'(hcount_out), 128'(0));
        check("reset v", 128'(vcount_out), 128'(0));
        check("reset busy", 128'(busy_out), 128'(0));
        check("reset done", 128'(frame_done_out), 128'(0));
        check("reset origin", 128'(ray_origin_out), 128'(0));
        rst_n_in = 1'b1;

        // All units ready: straight round robin over the 8 pixels
        add(1, 4'hF, 4'h0, 0, 0, 1, 0);
        add(0, 4'hF, 4'h1, 0, 0, 1, 0);
        add(0, 4'hF, 4'h2, 1, 0, 1, 0);
        add(0, 4'hF, 4'h4, 2, 0, 1, 0);
        add(0, 4'hF, 4'h8, 3, 0, 1, 0);
        add(0, 4'hF, 4'h1, 0, 1, 1, 0);
        add(0, 4'hF, 4'h2, 1, 1, 1, 0);
        add(0, 4'hF, 4'h4, 2, 1, 1, 0);
        add(0, 4'hF, 4'h8, 3, 1, 1, 0);
        add(0, 4'hF, 4'h0, 3, 1, 1, 0);
        add(0, 4'hF, 4'h0, 3, 1, 0, 1);
        add(0, 4'hF, 4'h0, 3, 1, 0, 0);
        // Only unit 2 ready: mask forces a grant every other cycle
        add(1, 4'h4, 4'h0, 3, 1, 1, 0);
        for (int k = 0; k < 16; k++) begin
            add(0, 4'h4, (k % 2 == 0) ? 4'h4 : 4'h0, (k / 2) % W, (k / 2) / W, 1, 0);
        end
        add(0, 4'h4, 4'h0, 3, 1, 1, 0);
        add(0, 4'hF, 4'h0, 3, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            frame_start_in = tbl[i].start;
            unit_ready_in  = tbl[i].ready;
            step();
            check($sformatf("vec%0d valid", i), 128'(unit_valid_out), 128'(tbl[i].valid));
            check($sformatf("vec%0d h", i), 128'(hcount_out), 128'(tbl[i].h));
            check($sformatf("vec%0d v", i), 128'(vcount_out), 128'(tbl[i].v));
            check($sformatf("vec%0d busy", i), 128'(busy_out), 128'(tbl[i].busy));
            check($sformatf("vec%0d done", i), 128'(frame_done_out), 128'(tbl[i].done));
        end
        frame_start_in = 1'b0;
        check("tbl origin", 128'(ray_origin_out), 128'(ORG1));
        check("tbl direction", 128'(ray_direction_out), 128'(FWD1));

        // Stall mid-frame with an ignored frame_start carrying a new origin
        cam_origin_in  = ORG2;
        fractal_sel_in = 3'd5;
        unit_ready_in  = 4'hF;
        frame_start_in = 1'b1;
        step();
        frame_start_in = 1'b0;
        issue_grants(0, 3, 4'h0, "stall pre");
        unit_ready_in = 4'h0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                cam_origin_in  = ORG3;
                frame_start_in = 1'b1;
            end else begin
                frame_start_in = 1'b0;
            end
            step();
            check($sformatf("stall c%0d valid", c), 128'(unit_valid_out), 128'(0));
            check($sformatf("stall c%0d h", c), 128'(hcount_out), 128'(2));
            check($sformatf("stall c%0d v", c), 128'(vcount_out), 128'(0));
            check($sformatf("stall c%0d origin", c), 128'(ray_origin_out), 128'(ORG2));
            check($sformatf("stall c%0d busy", c), 128'(busy_out), 128'(1));
        end
        frame_start_in = 1'b0;
        unit_ready_in  = 4'hF;
        step();
        check("resume valid", 128'(unit_valid_out), 128'(4'h4));
        check("resume h", 128'(hcount_out), 128'(3));
        check("resume v", 128'(vcount_out), 128'(0));
        issue_grants(4, 4, 4'h0, "stall post");
        check("stall post origin", 128'(ray_origin_out), 128'(ORG2));
        wait_done(6, "stall");
        check("stall done origin", 128'(ray_origin_out), 128'(ORG2));
        check("stall done sel", 128'(fractal_sel_out), 128'(5));

        // Unit 1 never ready: drain must wait for it
        unit_ready_in  = 4'b1101;
        frame_start_in = 1'b1;
        step();
        frame_start_in = 1'b0;
        issue_grants(0, 8, 4'b0010, "drain");
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("drain hold c%0d done", c), 128'(frame_done_out), 128'(0));
            check($sformatf("drain hold c%0d busy", c), 128'(busy_out), 128'(1));
        end
        unit_ready_in = 4'hF;
        step();
        check("drain release done", 128'(frame_done_out), 128'(1));
        step();
        check("drain after done", 128'(frame_done_out), 128'(0));
        check("drain after busy", 128'(busy_out), 128'(0));

        // Asynchronous reset between edges mid-frame
        frame_start_in = 1'b1;
        step();
        frame_start_in = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async rst valid", 128'(unit_valid_out), 128'(0));
        check("async rst h", 128'(hcount_out), 128'(0));
        check("async rst v", 128'(vcount_out), 128'(0));
        check("async rst busy", 128'(busy_out), 128'(0));
        check("async rst origin", 128'(ray_origin_out), 128'(0));
        check("async rst sel", 128'(fractal_sel_out), 128'(0));
        step();
        rst_n_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("post rst c%0d done", c), 128'(frame_done_out), 128'(0));
            check($sformatf("post rst c%0d valid", c), 128'(unit_valid_out), 128'(0));
        end
        frame_start_in = 1'b1;
        step();
        frame_start_in = 1'b0;
        step();
        check("restart valid", 128'(unit_valid_out), 128'(4'h1));
        check("restart h", 128'(hcount_out), 128'(0));
        check("restart v", 128'(vcount_out), 128'(0));
        issue_grants(1, 7, 4'h0, "restart");
        wait_done(6, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 Parameters SHALL be: NUM_UNITS, default 4, number of downstream ray units; DISPLAY_WIDTH, default `DISPLAY_WIDTH, pixels per line; DISPLAY_HEIGHT, default `DISPLAY_HEIGHT, lines per frame; H_BITS, default `H_BITS, hcount width; V_BITS, default `V_BITS, vcount width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_in  in  1  single clock.
- rst_n_in  in  1  reset, asynchronous and active-low.
- frame_start_in  in  1  one-cycle request to render a frame.
- cam_origin_in  in  vec3  camera position.
- cam_forward_in  in  vec3  camera forward vector.
- fractal_sel_in  in  3  scene select.
- unit_ready_in  in  NUM_UNITS  per-unit ready_out.
- unit_valid_out  out  NUM_UNITS  one-hot issue strobe.
- ray_origin_out  out  vec3  broadcast camera origin.
- ray_direction_out  out  vec3  broadcast forward vector.
- fractal_sel_out  out  3  broadcast scene select.
- hcount_out  out  H_BITS  issued pixel x.
- vcount_out  out  V_BITS  issued pixel y.
- busy_out  out  1  frame in progress.
- frame_done_out  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states DS_Idle, DS_Dispatch and DS_Drain.
REQ-004 In DS_Idle, frame_start_in high SHALL latch cam_origin_in, cam_forward_in and fractal_sel_in, set the pixel cursor to (0,0) and move to DS_Dispatch on the next edge.
REQ-005 frame_start_in SHALL be ignored in DS_Dispatch and DS_Drain.
REQ-006 ray_origin_out, ray_direction_out and fractal_sel_out SHALL come from the latched registers and SHALL stay constant from the latch until the next accepted frame_start_in.
REQ-007 A unit is eligible when unit_ready_in[i] is high and it was not issued on the previous cycle; the issue mask covers the one cycle in which a just-issued unit still reports ready.
REQ-008 In DS_Dispatch, each cycle with at least one eligible unit SHALL grant exactly one unit by round-robin, searching from (last granted + 1) mod NUM_UNITS.
REQ-009 On a grant, the registered outputs SHALL be updated on the same edge: unit_valid_out is the one-hot grant, and hcount_out/vcount_out are the cursor; the cursor then advances.
REQ-010 unit_valid_out SHALL be high for exactly one cycle per grant and SHALL be all-zero on cycles without a grant.
REQ-011 The cursor SHALL advance hcount 0..DISPLAY_WIDTH-1. At DISPLAY_WIDTH-1 it SHALL wrap to 0 and increment vcount.
REQ-012 Granting pixel (DISPLAY_WIDTH-1, DISPLAY_HEIGHT-1) SHALL move the FSM to DS_Drain; no further grants occur in that frame.
REQ-013 In DS_Drain, when all unit_ready_in bits are high and the issue mask is empty, the block SHALL pulse frame_done_out for one cycle and return to DS_Idle.
REQ-014 busy_out SHALL be high in DS_Dispatch and DS_Drain, and low in DS_Idle.
REQ-015 Each pixel of a frame SHALL be issued exactly once, in raster order; throughput is at most one pixel per cycle.
REQ-016 If no unit is eligible, the block SHALL stall with the cursor held and outputs unchanged except unit_valid_out=0.

Reset
REQ-017 Asserting rst_n_in low SHALL, asynchronously, force DS_Idle, set all outputs to zero, clear the cursor and issue mask, and set the round-robin pointer to unit 0.
REQ-018 Reset mid-frame SHALL abandon the frame with no frame_done_out pulse; rendering resumes only on a new frame_start_in after release.

Structure
REQ-019 The DispatchState enum SHALL be added to the shared types package alongside RayUnitState; vec3 and fp SHALL be reused from it, and display constants SHALL come from the existing defines.
REQ-020 The round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; outputs: one-hot grant and any-grant), which is purely combinational.

Verification
REQ-021 Use NUM_UNITS=4, a 4x2 display, all units always ready, and frame_start at cycle 0. Required: grants 0,1,2,3,0,1,2,3 on consecutive cycles with pixels (0,0)..(3,1); frame_done 1 cycle after the last grant plus mask clear; busy low afterwards.
REQ-022 Only unit 2 ready, held high by the bench. Required: grants to unit 2 on alternate cycles only (mask honoured); 8 pixels issued in 16 cycles.
REQ-023 All units not ready for 10 cycles mid-frame. Required: cursor frozen; unit_valid_out=0 throughout; issue resumes at the held pixel when a unit becomes ready.
REQ-024 frame_start pulsed during DS_Dispatch with a different cam_origin_in. Required: ignored, and ray_origin_out unchanged until frame_done.
REQ-025 rst_n_in asserted low between clock edges mid-frame. Required: outputs zero immediately, without waiting for an edge; no frame_done_out; a new frame restarts at (0,0) with the pointer at unit 0.
REQ-026 Unit 1 ready low at the end of the frame. Required: DS_Drain holds and frame_done_out is withheld until unit 1 asserts ready, then pulses once.
